// File: rtl/chi_pkg.sv
// Shared types and the row transform for chi_row_engine.
package chi_pkg;

   // Widest row-vector chi_row() supports; callers zero-extend narrower rows.
   localparam int unsigned MAX_ROWS = 64;

   localparam logic MODE_CHI    = 1'b0;
   localparam logic MODE_BYPASS = 1'b1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

   // out[i] = a[i] ^ (~a[i+1] & a[i+2]), indices wrapping modulo rows.
   function automatic logic [MAX_ROWS-1:0] chi_row(input logic [MAX_ROWS-1:0] a,
                                                   input int unsigned rows);
      logic [MAX_ROWS-1:0] res;
      int unsigned i1;
      int unsigned i2;
      res = '0;
      for (int unsigned i = 0; i < MAX_ROWS; i++) begin
         i1 = 0;
         i2 = 0;
         if (i < rows) begin
            i1 = (i + 1) % rows;
            i2 = (i + 2) % rows;
            res[i[5:0]] = a[i[5:0]] ^ (~a[i1[5:0]] & a[i2[5:0]]);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/chi_row_fifo.sv
// Two-entry {addr, data} result buffer; push while full is honoured only with a same-cycle pop.
module chi_row_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 2'd1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 2'd1;
         end
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);

endmodule

// File: rtl/chi_row_engine.sv
// Row-at-a-time chi/bypass sweep over a COLS x PAGES state with a 2-entry write buffer.
// Optional iota injection on column 0 rows is enabled by defining CHI_IOTA_EN.
module chi_row_engine
   import chi_pkg::*;
#(
   parameter int unsigned ROWS   = 5,
   parameter int unsigned COLS   = 5,
   parameter int unsigned PAGES  = 64,
   parameter int unsigned ADDR_W = $clog2(COLS * PAGES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [ROWS-1:0]   rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ROWS-1:0]   wr_data,
   input  logic              wr_ready,
`ifdef CHI_IOTA_EN
   input  logic [PAGES-1:0]  rc,
`endif
   output logic              busy,
   output logic              done
);

   localparam int unsigned JW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned KW = (PAGES > 1) ? $clog2(PAGES) : 1;

   state_e            state_q, state_d;
   logic [JW-1:0]     j_q;
   logic [KW-1:0]     k_q;
   logic              mode_q;
   logic              rd_vld_q;
   logic [ADDR_W-1:0] rd_addr_q;
`ifdef CHI_IOTA_EN
   logic [JW-1:0]     rd_j_q;
   logic [KW-1:0]     rd_k_q;
`endif

   logic                 last_j;
   logic                 last_k;
   logic                 last_rd;
   logic                 credit_ok;
   logic                 pop;
   logic [MAX_ROWS-1:0]  chi_full;
   logic [ROWS-1:0]      xf_data;
   logic [ADDR_W+ROWS-1:0] fifo_head;
   logic [1:0]           fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign last_j  = (j_q == JW'(COLS - 1));
   assign last_k  = (k_q == KW'(PAGES - 1));
   assign rd_addr = ADDR_W'(32'(k_q) * COLS + 32'(j_q));

   // A read may issue only if its return finds a free slot, counting this cycle's pop.
   assign pop       = wr_en && wr_ready;
   assign credit_ok = fifo_full ? pop : !((fifo_count == 2'd1) && rd_vld_q && !pop);
   assign rd_en     = (state_q == StRun) && credit_ok;
   assign last_rd   = rd_en && last_j && last_k;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last_rd) state_d = StDrain;
         StDrain: if (fifo_empty && !rd_vld_q) state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         j_q       <= '0;
         k_q       <= '0;
         mode_q    <= MODE_CHI;
         rd_vld_q  <= 1'b0;
         rd_addr_q <= '0;
`ifdef CHI_IOTA_EN
         rd_j_q    <= '0;
         rd_k_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rd_vld_q <= rd_en;
         if ((state_q == StIdle) && start) begin
            mode_q <= mode;
         end
         if (rd_en) begin
            rd_addr_q <= rd_addr;
`ifdef CHI_IOTA_EN
            rd_j_q    <= j_q;
            rd_k_q    <= k_q;
`endif
            if (last_j) begin
               j_q <= '0;
               k_q <= last_k ? '0 : k_q + KW'(1);
            end else begin
               j_q <= j_q + JW'(1);
            end
         end
      end
   end

   // ROWS must not exceed MAX_ROWS; the row is zero-extended into the shared transform.
   always_comb begin
      chi_full = chi_row(MAX_ROWS'(rd_data), ROWS);
      if (mode_q == MODE_BYPASS) begin
         xf_data = rd_data;
      end else begin
         xf_data = chi_full[ROWS-1:0];
`ifdef CHI_IOTA_EN
         if (rd_j_q == '0) begin
            xf_data[0] = xf_data[0] ^ rc[rd_k_q];
         end
`endif
      end
   end

   chi_row_fifo #(
      .WIDTH(ADDR_W + ROWS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_vld_q),
      .push_data ({rd_addr_q, xf_data}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wr_en   = !fifo_empty;
   assign wr_addr = wr_en ? fifo_head[ADDR_W+ROWS-1:ROWS] : '0;
   assign wr_data = wr_en ? fifo_head[ROWS-1:0] : '0;
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StFin);

endmodule

// File: tb/tb_chi_row_engine.sv
// Scoreboard bench for chi_row_engine: expected rows queued at read issue, checked at write.
module tb_chi_row_engine;

   localparam int ROWS   = 5;
   localparam int COLS   = 5;
   localparam int PAGES  = 64;
   localparam int ADDR_W = 9;
   localparam int N      = COLS * PAGES;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic              wr_ready = 1'b1;
   logic              rd_en, wr_en, busy, done;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [ROWS-1:0]   rd_data, wr_data;
`ifdef CHI_IOTA_EN
   logic [PAGES-1:0]  rc = '0;
`endif

   typedef struct {
      int              addr;
      logic [ROWS-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   reads, writes, dones, done_cyc, max_out, exp_rd_addr, rst_activity;
   int   pat = 0;
   logic exp_mode = 1'b0;
   logic stall_prev = 1'b0;
   logic [ADDR_W-1:0] prev_addr;
   logic [ROWS-1:0]   prev_data;

   chi_row_engine #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .PAGES (PAGES),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_ready(wr_ready),
`ifdef CHI_IOTA_EN
      .rc      (rc),
`endif
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [ROWS-1:0] mem_row(input int addr, input int sel);
      case (sel)
         0:       return 5'b00101;
         1:       return 5'(addr);
         2:       return 5'b00000;
         default: return 5'((addr * 7 + (addr >> 3)) ^ 5'h15);
      endcase
   endfunction

   function automatic logic [ROWS-1:0] ref_chi(input logic [ROWS-1:0] a);
      logic [ROWS-1:0] r;
      for (int i = 0; i < ROWS; i++) begin
         r[i] = a[i] ^ (~a[(i + 1) % ROWS] & a[(i + 2) % ROWS]);
      end
      return r;
   endfunction

   function automatic logic [ROWS-1:0] expect_row(input int addr);
      logic [ROWS-1:0] r;
      if (exp_mode) return mem_row(addr, pat);
      r = (pat == 0) ? 5'b01100 : ref_chi(mem_row(addr, pat));
`ifdef CHI_IOTA_EN
      if (addr % COLS == 0) r[0] = r[0] ^ rc[addr / COLS];
`endif
      return r;
   endfunction

   // Row memory with one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem_row(int'(rd_addr), pat);
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if ((reads - writes >= 2) && !(wr_en && wr_ready)) check("rd_suppress", rd_en, 1'b0);
         if (rd_en) begin
            check("rd_addr", rd_addr, exp_rd_addr);
            sb_q.push_back('{addr: exp_rd_addr, data: expect_row(exp_rd_addr)});
            exp_rd_addr++;
            reads++;
         end
         if (stall_prev) begin
            check("stall_wr_en", wr_en, 1'b1);
            check("stall_wr_addr", wr_addr, prev_addr);
            check("stall_wr_data", wr_data, prev_data);
         end
         if (wr_en && wr_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("wr_addr", wr_addr, e.addr);
               check("wr_data", wr_data, e.data);
            end
            writes++;
         end
         if (reads - writes > max_out) max_out = reads - writes;
         stall_prev = wr_en && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
         if (done) begin
            dones++;
            done_cyc = cyc - start_cyc + 1;
         end
      end else begin
         if (rd_en || wr_en || done || busy) rst_activity++;
         stall_prev = 1'b0;
      end
   end

   task automatic clear_sb(input logic m, input int sel);
      sb_q.delete();
      exp_mode    = m;
      pat         = sel;
      reads       = 0;
      writes      = 0;
      dones       = 0;
      done_cyc    = 0;
      max_out     = 0;
      exp_rd_addr = 0;
   endtask

   task automatic pulse_start(input logic m);
      @(posedge clk);
      #1 start = 1'b1;
      mode = m;
      @(posedge clk);
      #1 start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic run_sweep(input string name, input logic m, input int sel, input bit stall,
                            input bit repulse, input bit timed);
      clear_sb(m, sel);
      pulse_start(m);
      check({name, "_busy"}, busy, 1'b1);
      if (repulse) begin
         repeat (20) @(posedge clk);
         #1 start = 1'b1;
         mode = ~m;
         @(posedge clk);
         #1 start = 1'b0;
      end
      if (stall) begin
         for (int c = 0; c < 1000 && writes < 50; c++) @(posedge clk);
         #1 wr_ready = 1'b0;
         repeat (10) @(posedge clk);
         #1 wr_ready = 1'b1;
      end
      for (int c = 0; c < 2000 && dones == 0; c++) @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      check({name, "_dones"}, dones, 1);
      check({name, "_writes"}, writes, N);
      check({name, "_reads"}, reads, N);
      check({name, "_sb_left"}, sb_q.size(), 0);
      check({name, "_max_out_le2"}, (max_out <= 2), 1'b1);
      check({name, "_idle"}, busy, 1'b0);
      if (timed) check({name, "_done_cycle"}, done_cyc, 324);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_en", rd_en, 1'b0);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      rst = 1'b1;

      run_sweep("chi_const", 1'b0, 0, 1'b0, 1'b0, 1'b1);
      run_sweep("bypass", 1'b1, 1, 1'b0, 1'b0, 1'b1);
      run_sweep("stall", 1'b0, 3, 1'b1, 1'b0, 1'b0);
      run_sweep("restart_ign", 1'b0, 3, 1'b0, 1'b1, 1'b1);
      mode = 1'b0;

      // Abort mid-sweep at the 100th write.
      clear_sb(1'b0, 3);
      pulse_start(1'b0);
      for (int c = 0; c < 1000 && writes < 100; c++) @(posedge clk);
      check("abort_reached", (writes >= 100), 1'b1);
      #1 rst = 1'b0;
      #1;
      check("abort_rd_en", rd_en, 1'b0);
      check("abort_wr_en", wr_en, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_rd_addr", rd_addr, 0);
      check("abort_wr_addr", wr_addr, 0);
      check("abort_wr_data", wr_data, 0);
      rst_activity = 0;
      repeat (3) @(posedge clk);
      #1 check("abort_quiet", rst_activity, 0);
      rst = 1'b1;
      run_sweep("after_abort", 1'b0, 3, 1'b0, 1'b0, 1'b1);

`ifdef CHI_IOTA_EN
      rc = 64'h1;
      run_sweep("iota", 1'b0, 2, 1'b0, 1'b0, 1'b1);
      rc = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
